reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter_pkg.sv | 19 +
 rtl/reg_wb_arbiter_fifo.sv | 62 ++++++
 rtl/reg_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg - shared types and constants for the register-file
// writeback arbiter slice (FSM states, write-request record, zero register).
package reg_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // result buffer empty
        ST_DRAIN = 2'd1,   // buffer holds results, pipeline has priority
        ST_FORCE = 2'd2    // buffered head preempts the pipeline
    } arb_state_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo - small circular buffer of long-latency writeback results.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import reg_wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        SYS_reset,
    input  logic                        push,
    input  wr_req_t                     push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output wr_req_t                     head,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    wr_req_t       mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Entry storage; validity is defined by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter - arbitrates the single register-file write port between the
// main pipeline and buffered long-latency results, with anti-starvation
// preemption. Optional scoreboard built when REG_WB_SCOREBOARD_EN is defined.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        SYS_reset,
    input  logic        PIPE_wr_en,
    input  logic [4:0]  PIPE_wr_addr,
    input  logic [31:0] PIPE_wr_data,
    output logic        PIPE_hold,
    input  logic        LONG_valid,
    input  logic [4:0]  LONG_addr,
    input  logic [31:0] LONG_data,
    output logic        LONG_ready,
    output logic        REG_write_enable,
    output logic [4:0]  REG_address_wr,
    output logic [31:0] REG_write_data,
    input  logic        SB_issue,
    input  logic [4:0]  SB_issue_addr,
    input  logic [4:0]  SB_rs_addr,
    input  logic [4:0]  SB_rt_addr,
    output logic        SB_stall
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    wr_req_t       fifo_head;
    wr_req_t       push_req;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_after;
    wr_req_t       grant;

    assign fifo_push  = LONG_valid && LONG_ready;
    assign LONG_ready = !fifo_full;
    assign PIPE_hold  = (state == ST_FORCE);
    assign push_req   = '{en: 1'b1, addr: LONG_addr, data: LONG_data};

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .SYS_reset (SYS_reset),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // State and starvation counter registers.
    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Grant selection, starvation tracking and next state.
    always_comb begin
        grant      = '0;
        fifo_pop   = 1'b0;
        starve_nxt = starve_cnt;
        state_nxt  = state;

        if (state == ST_FORCE) begin
            grant    = fifo_head;
            fifo_pop = 1'b1;
        end else if (PIPE_wr_en) begin
            grant = '{en: 1'b1, addr: PIPE_wr_addr, data: PIPE_wr_data};
        end else if (!fifo_empty) begin
            grant    = fifo_head;
            fifo_pop = 1'b1;
        end

        if (fifo_pop) begin
            starve_nxt = '0;
        end else if (state == ST_DRAIN) begin
            starve_nxt = starve_cnt + SW'(1);
        end

        // State follows occupancy after this cycle's push/pop, unless starved.
        cnt_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        if (state == ST_DRAIN && !fifo_pop && starve_nxt >= SW'(STARVE_LIMIT)) begin
            state_nxt = ST_FORCE;
        end else if (cnt_after != '0) begin
            state_nxt = ST_DRAIN;
        end else begin
            state_nxt = ST_IDLE;
        end
    end

    // Registered write port; writes to the zero register are consumed silently.
    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            REG_write_enable <= 1'b0;
            REG_address_wr   <= '0;
            REG_write_data   <= '0;
        end else begin
            REG_write_enable <= grant.en && (grant.addr != REG_ZERO);
            REG_address_wr   <= grant.addr;
            REG_write_data   <= grant.data;
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    logic [31:0] pending;

    // Pending-result tracking; an issue in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            pending <= '0;
        end else begin
            if (fifo_pop) begin
                pending[fifo_head.addr] <= 1'b0;
            end
            if (SB_issue && SB_issue_addr != REG_ZERO) begin
                pending[SB_issue_addr] <= 1'b1;
            end
        end
    end

    assign SB_stall = pending[SB_rs_addr] | pending[SB_rt_addr];
`else
    logic sb_unused;
    assign sb_unused = ^{SB_issue, SB_issue_addr, SB_rs_addr, SB_rt_addr};
    assign SB_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter - self-checking bench for reg_wb_arbiter with a
// queue-based reference model of the writeback arbitration rules.
module tb_reg_wb_arbiter;

    localparam int unsigned FIFO_DEPTH   = 2;
    localparam int unsigned STARVE_LIMIT = 4;
`ifdef REG_WB_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        SYS_reset;
    logic        PIPE_wr_en;
    logic [4:0]  PIPE_wr_addr;
    logic [31:0] PIPE_wr_data;
    logic        PIPE_hold;
    logic        LONG_valid;
    logic [4:0]  LONG_addr;
    logic [31:0] LONG_data;
    logic        LONG_ready;
    logic        REG_write_enable;
    logic [4:0]  REG_address_wr;
    logic [31:0] REG_write_data;
    logic        SB_issue;
    logic [4:0]  SB_issue_addr;
    logic [4:0]  SB_rs_addr;
    logic [4:0]  SB_rt_addr;
    logic        SB_stall;

    int n_checks = 0;
    int n_fail   = 0;

    reg_wb_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk              (clk),
        .SYS_reset        (SYS_reset),
        .PIPE_wr_en       (PIPE_wr_en),
        .PIPE_wr_addr     (PIPE_wr_addr),
        .PIPE_wr_data     (PIPE_wr_data),
        .PIPE_hold        (PIPE_hold),
        .LONG_valid       (LONG_valid),
        .LONG_addr        (LONG_addr),
        .LONG_data        (LONG_data),
        .LONG_ready       (LONG_ready),
        .REG_write_enable (REG_write_enable),
        .REG_address_wr   (REG_address_wr),
        .REG_write_data   (REG_write_data),
        .SB_issue         (SB_issue),
        .SB_issue_addr    (SB_issue_addr),
        .SB_rs_addr       (SB_rs_addr),
        .SB_rt_addr       (SB_rt_addr),
        .SB_stall         (SB_stall)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          m_starve;
    bit          m_force;
    bit          m_pend [32];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_force  = 1'b0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One clock of the arbitration rules, using the inputs currently driven.
    task automatic model_step();
        bit   waiting;
        bit   popped;
        bit   accept;
        ent_t h;
        ent_t e;
        waiting = (q.size() != 0) && !m_force;
        popped  = 1'b0;
        accept  = LONG_valid && (q.size() < FIFO_DEPTH);
        if (m_force || (!PIPE_wr_en && q.size() != 0)) begin
            h      = q.pop_front();
            popped = 1'b1;
            m_we   = (h.a != 5'd0);
            m_addr = h.a;
            m_data = h.d;
            m_pend[h.a] = 1'b0;
        end else if (PIPE_wr_en) begin
            m_we   = (PIPE_wr_addr != 5'd0);
            m_addr = PIPE_wr_addr;
            m_data = PIPE_wr_data;
        end else begin
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end
        if (popped) begin
            m_starve = 0;
            m_force  = 1'b0;
        end else if (waiting) begin
            m_starve++;
            if (m_starve >= STARVE_LIMIT) m_force = 1'b1;
        end
        if (accept) begin
            e.a = LONG_addr;
            e.d = LONG_data;
            q.push_back(e);
        end
        if (SB_ON && SB_issue && SB_issue_addr != 5'd0) m_pend[SB_issue_addr] = 1'b1;
    endtask

    function automatic logic m_stall();
        return SB_ON && (m_pend[SB_rs_addr] || m_pend[SB_rt_addr]);
    endfunction

    task automatic idle_inputs();
        PIPE_wr_en    = 1'b0;
        PIPE_wr_addr  = '0;
        PIPE_wr_data  = '0;
        LONG_valid    = 1'b0;
        LONG_addr     = '0;
        LONG_data     = '0;
        SB_issue      = 1'b0;
        SB_issue_addr = '0;
        SB_rs_addr    = '0;
        SB_rt_addr    = '0;
    endtask

    // Advance model and DUT by one clock; returns #1 after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (FIFO_DEPTH + 2) cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        SYS_reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", REG_write_enable); end
        n_checks++; if (REG_address_wr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", REG_address_wr); end
        n_checks++; if (REG_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", REG_write_data); end
        n_checks++; if (PIPE_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %b want 0", PIPE_hold); end
        n_checks++; if (LONG_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", LONG_ready); end
        n_checks++; if (SB_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", SB_stall); end
        SYS_reset = 1'b0;
    endtask

    task automatic test_idle_drain();
        idle_inputs();
        LONG_valid = 1'b1; LONG_addr = 5'd5; LONG_data = 32'hDEADBEEF;
        cycle();
        LONG_valid = 1'b0;
        n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL drain_early_we got %b want 0", REG_write_enable); end
        cycle();
        n_checks++; if (REG_write_enable !== 1'b1) begin n_fail++; $display("FAIL drain_we got %b want 1", REG_write_enable); end
        n_checks++; if (REG_address_wr !== 5'd5) begin n_fail++; $display("FAIL drain_addr got %0d want 5", REG_address_wr); end
        n_checks++; if (REG_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL drain_data got %h want deadbeef", REG_write_data); end
        cycle();
        n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL drain_after_we got %b want 0", REG_write_enable); end
    endtask

    task automatic test_contention();
        idle_inputs();
        PIPE_wr_en = 1'b1; PIPE_wr_addr = 5'd3; PIPE_wr_data = 32'h11;
        LONG_valid = 1'b1; LONG_addr = 5'd7; LONG_data = 32'h22;
        cycle();
        LONG_valid = 1'b0;
        // Once r7 is buffered, the pipeline keeps the port for STARVE_LIMIT cycles.
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            #1;
            n_checks++; if (PIPE_hold !== 1'b0) begin n_fail++; $display("FAIL cont_hold_early[%0d] got %b want 0", i, PIPE_hold); end
            cycle();
            n_checks++; if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'd3 || REG_write_data !== 32'h11)
                begin n_fail++; $display("FAIL cont_pipe[%0d] got we=%b a=%0d d=%h want we=1 a=3 d=11", i, REG_write_enable, REG_address_wr, REG_write_data); end
        end
        #1;
        n_checks++; if (PIPE_hold !== 1'b1) begin n_fail++; $display("FAIL cont_hold got %b want 1", PIPE_hold); end
        cycle();
        n_checks++; if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'd7 || REG_write_data !== 32'h22)
            begin n_fail++; $display("FAIL cont_force got we=%b a=%0d d=%h want we=1 a=7 d=22", REG_write_enable, REG_address_wr, REG_write_data); end
        #1;
        n_checks++; if (PIPE_hold !== 1'b0) begin n_fail++; $display("FAIL cont_hold_release got %b want 0", PIPE_hold); end
        cycle();
        n_checks++; if (REG_address_wr !== 5'd3) begin n_fail++; $display("FAIL cont_resume got a=%0d want 3", REG_address_wr); end
        drain();
    endtask

    task automatic test_full();
        logic [4:0]  wa[$];
        logic [31:0] wd[$];
        logic [31:0] dv [3];
        int idx     = 0;
        int third_c = -1;
        for (int i = 0; i < 3; i++) dv[i] = $urandom;
        idle_inputs();
        PIPE_wr_en = 1'b1; PIPE_wr_addr = 5'd4; PIPE_wr_data = 32'h4444_0000;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            LONG_valid = 1'b1; LONG_addr = 5'(10 + idx); LONG_data = dv[idx];
            #1;
            n_checks++; if (LONG_ready !== (q.size() < FIFO_DEPTH)) begin n_fail++; $display("FAIL full_ready[%0d] got %b want %b", c, LONG_ready, q.size() < FIFO_DEPTH); end
            if (c == 2) begin
                n_checks++; if (LONG_ready !== 1'b0) begin n_fail++; $display("FAIL full_after_two got %b want 0", LONG_ready); end
            end
            if (LONG_ready === 1'b1) begin
                if (idx == 2) third_c = c;
                idx++;
            end
            cycle();
            if (REG_write_enable === 1'b1 && REG_address_wr !== 5'd4) begin wa.push_back(REG_address_wr); wd.push_back(REG_write_data); end
        end
        n_checks++; if (third_c != STARVE_LIMIT + 2) begin n_fail++; $display("FAIL full_third_accept got cycle %0d want %0d", third_c, STARVE_LIMIT + 2); end
        idle_inputs();
        repeat (FIFO_DEPTH + 2) begin
            cycle();
            if (REG_write_enable === 1'b1) begin wa.push_back(REG_address_wr); wd.push_back(REG_write_data); end
        end
        n_checks++;
        if (wa.size() != 3) begin
            n_fail++; $display("FAIL full_write_count got %0d want 3", wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (wa[i] !== 5'(10 + i) || wd[i] !== dv[i])
                    begin n_fail++; $display("FAIL full_order[%0d] got a=%0d d=%h want a=%0d d=%h", i, wa[i], wd[i], 10 + i, dv[i]); end
            end
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        SB_rs_addr = 5'd9;
        SB_issue = 1'b1; SB_issue_addr = 5'd9;
        #1;
        n_checks++; if (SB_stall !== 1'b0) begin n_fail++; $display("FAIL sb_before got %b want 0", SB_stall); end
        cycle();
        SB_issue = 1'b0;
        LONG_valid = 1'b1; LONG_addr = 5'd9; LONG_data = 32'h9999;
        #1;
        n_checks++; if (SB_stall !== SB_ON) begin n_fail++; $display("FAIL sb_pending got %b want %b", SB_stall, SB_ON); end
        cycle();
        LONG_valid = 1'b0;
        #1;
        n_checks++; if (SB_stall !== SB_ON) begin n_fail++; $display("FAIL sb_grant_cycle got %b want %b", SB_stall, SB_ON); end
        cycle();
        n_checks++; if (SB_stall !== 1'b0) begin n_fail++; $display("FAIL sb_cleared got %b want 0", SB_stall); end
        n_checks++; if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'd9) begin n_fail++; $display("FAIL sb_write got we=%b a=%0d want we=1 a=9", REG_write_enable, REG_address_wr); end
        // Re-issue of r9 in the very cycle its result is granted.
        SB_issue = 1'b1; SB_issue_addr = 5'd9;
        cycle();
        SB_issue = 1'b0;
        LONG_valid = 1'b1; LONG_addr = 5'd9; LONG_data = 32'h9A9A;
        cycle();
        LONG_valid = 1'b0;
        SB_issue = 1'b1; SB_issue_addr = 5'd9;
        cycle();
        SB_issue = 1'b0;
        SB_rs_addr = 5'd0; SB_rt_addr = 5'd9;
        #1;
        n_checks++; if (SB_stall !== SB_ON) begin n_fail++; $display("FAIL sb_reissue got %b want %b", SB_stall, SB_ON); end
        LONG_valid = 1'b1; LONG_addr = 5'd9; LONG_data = 32'h9B9B;
        cycle();
        LONG_valid = 1'b0;
        cycle();
        n_checks++; if (SB_stall !== 1'b0) begin n_fail++; $display("FAIL sb_rt_cleared got %b want 0", SB_stall); end
        drain();
    endtask

    task automatic test_zero();
        idle_inputs();
        LONG_valid = 1'b1; LONG_addr = 5'd0; LONG_data = 32'hFFFF_FFFF;
        cycle();
        LONG_valid = 1'b0;
        n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL zero_long_c0 got %b want 0", REG_write_enable); end
        cycle();
        n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL zero_long_pop got %b want 0", REG_write_enable); end
        PIPE_wr_en = 1'b1; PIPE_wr_addr = 5'd0; PIPE_wr_data = 32'h1234;
        cycle();
        PIPE_wr_en = 1'b0;
        n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL zero_pipe got %b want 0", REG_write_enable); end
        // If r0 had not been popped it would be written ahead of r6.
        LONG_valid = 1'b1; LONG_addr = 5'd6; LONG_data = 32'h6666;
        cycle();
        LONG_valid = 1'b0;
        cycle();
        n_checks++; if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'd6 || REG_write_data !== 32'h6666)
            begin n_fail++; $display("FAIL zero_next got we=%b a=%0d d=%h want we=1 a=6 d=6666", REG_write_enable, REG_address_wr, REG_write_data); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        PIPE_wr_en = 1'b1; PIPE_wr_addr = 5'd3; PIPE_wr_data = 32'h33;
        SB_issue = 1'b1; SB_issue_addr = 5'd12; SB_rs_addr = 5'd12;
        LONG_valid = 1'b1; LONG_addr = 5'd13; LONG_data = 32'h1313;
        cycle();
        SB_issue = 1'b0;
        LONG_addr = 5'd14; LONG_data = 32'h1414;
        cycle();
        LONG_valid = 1'b0;
        #1;
        n_checks++; if (LONG_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full got %b want 0", LONG_ready); end
        n_checks++; if (SB_stall !== SB_ON) begin n_fail++; $display("FAIL rmid_stall_pre got %b want %b", SB_stall, SB_ON); end
        SYS_reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (LONG_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", LONG_ready); end
        n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL rmid_we got %b want 0", REG_write_enable); end
        n_checks++; if (SB_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall got %b want 0", SB_stall); end
        n_checks++; if (PIPE_hold !== 1'b0) begin n_fail++; $display("FAIL rmid_hold got %b want 0", PIPE_hold); end
        @(posedge clk);
        #1;
        SYS_reset = 1'b0;
        PIPE_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++; if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL rmid_discard[%0d] got we=%b a=%0d want 0", i, REG_write_enable, REG_address_wr); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            PIPE_wr_en    = ($urandom_range(0, 9) < 7);
            PIPE_wr_addr  = 5'($urandom_range(0, 31));
            PIPE_wr_data  = $urandom;
            LONG_valid    = ($urandom_range(0, 2) == 0);
            LONG_addr     = 5'($urandom_range(0, 7));
            LONG_data     = $urandom;
            SB_issue      = ($urandom_range(0, 3) == 0);
            SB_issue_addr = 5'($urandom_range(0, 7));
            SB_rs_addr    = 5'($urandom_range(0, 7));
            SB_rt_addr    = 5'($urandom_range(0, 7));
            #1;
            n_checks++; if (PIPE_hold !== m_force) begin n_fail++; $display("FAIL rnd_hold[%0d] got %b want %b", c, PIPE_hold, m_force); end
            n_checks++; if (LONG_ready !== (q.size() < FIFO_DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", c, LONG_ready, q.size() < FIFO_DEPTH); end
            n_checks++; if (SB_stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall[%0d] got %b want %b", c, SB_stall, m_stall()); end
            cycle();
            n_checks++; if (REG_write_enable !== m_we) begin n_fail++; $display("FAIL rnd_we[%0d] got %b want %b", c, REG_write_enable, m_we); end
            if (m_we) begin
                n_checks++; if (REG_address_wr !== m_addr || REG_write_data !== m_data)
                    begin n_fail++; $display("FAIL rnd_write[%0d] got a=%0d d=%h want a=%0d d=%h", c, REG_address_wr, REG_write_data, m_addr, m_data); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_idle_drain();
        test_contention();
        test_full();
        test_scoreboard();
        test_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
